// File: rtl/rgbled_pkg.sv
// rtl/rgbled_pkg.sv - shared types and helpers for the RGB LED frame sequencer
package rgbled_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        DRAIN,
        GAP
    } rgbled_state_e;

    // WS281x parts shift green first, then red, then blue.
    function automatic logic [23:0] rgb_to_grb(input rgb_t c);
        return {c.g, c.r, c.b};
    endfunction

endpackage

// File: rtl/rgbled_if.sv
// rtl/rgbled_if.sv - word handshake between the frame sequencer and ws281x_drv
interface rgbled_if;

    logic        go;
    logic [23:0] data;
    logic        data_valid;
    logic        data_last;
    logic        data_ack;
    logic        drv_idle;

    modport master (
        output go, data, data_valid, data_last,
        input  data_ack, drv_idle
    );

    modport slave (
        input  go, data, data_valid, data_last,
        output data_ack, drv_idle
    );

endinterface

// File: rtl/rgbled_timer.sv
// rtl/rgbled_timer.sv - periodic refresh tick and post-frame latch gap counter
module rgbled_timer #(
    parameter int ClkFreq   = 25_000_000,
    parameter int RefreshHz = 100,
    parameter int MinGapUs  = 300
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic refresh_en_i,
    input  logic gap_clr_i,
    input  logic gap_run_i,
    output logic refresh_hit_o,
    output logic gap_done_o
);

    localparam int     RefreshCyc = (ClkFreq / RefreshHz < 1) ? 1 : ClkFreq / RefreshHz;
    localparam int     RW         = (RefreshCyc > 1) ? $clog2(RefreshCyc) : 1;
    // 64-bit product: MinGapUs * ClkFreq overflows 32 bits at default settings.
    localparam longint GapRaw     = longint'(MinGapUs) * longint'(ClkFreq) / longint'(1000000);
    localparam longint GapCyc     = (GapRaw < 1) ? 1 : GapRaw;
    localparam int     GW         = (GapCyc > 1) ? $clog2(GapCyc) : 1;

    localparam logic [RW-1:0] RefreshLast = RW'(RefreshCyc - 1);
    localparam logic [GW-1:0] GapLast     = GW'(GapCyc - 1);

    logic [RW-1:0] refresh_q, refresh_d;
    logic [GW-1:0] gap_q, gap_d;

    assign refresh_hit_o = refresh_en_i && (refresh_q == RefreshLast);
    assign gap_done_o    = (gap_q == GapLast);

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        if (!refresh_en_i || refresh_hit_o) begin
            refresh_d = '0;
        end
        gap_d = gap_q;
        if (gap_clr_i) begin
            gap_d = '0;
        end else if (gap_run_i && !gap_done_o) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refresh_q <= '0;
            gap_q     <= '0;
        end else begin
            refresh_q <= refresh_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: rtl/rgbled_ctrl.sv
// rtl/rgbled_ctrl.sv - per-LED colour store that snapshots and streams one frame to ws281x_drv
module rgbled_ctrl #(
    parameter  int NumLeds   = 2,
    parameter  int ClkFreq   = 25_000_000,
    parameter  int RefreshHz = 100,
    parameter  int MinGapUs  = 300,
    localparam int IW        = $clog2(NumLeds) | 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           wr_en_i,
    input  logic [IW-1:0]  wr_idx_i,
    input  logic [23:0]    wr_rgb_i,
    input  logic           update_i,
    input  logic           refresh_en_i,
    output logic           busy_o,
    rgbled_if.master       drv
);
    import rgbled_pkg::*;

    localparam int            AW      = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam logic [AW-1:0] LastIdx = AW'(NumLeds - 1);

    rgbled_state_e state_q;
    rgb_t          colour_q [NumLeds];
    rgb_t          shadow_q [NumLeds];
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_nx;
    logic          pend_q;
    logic          go_q;
    logic          valid_q;
    logic          last_q;
    logic [23:0]   data_q;
    logic          refresh_hit;
    logic          gap_done;
    logic          trigger;
    logic          wr_hit;

    assign idx_nx  = idx_q + 1'b1;
    assign trigger = update_i | refresh_hit;
    assign wr_hit  = wr_en_i && (32'(wr_idx_i) < NumLeds);

    assign busy_o          = (state_q != IDLE);
    assign drv.go          = go_q;
    assign drv.data        = data_q;
    assign drv.data_valid  = valid_q;
    assign drv.data_last   = last_q;

    rgbled_timer #(
        .ClkFreq   (ClkFreq),
        .RefreshHz (RefreshHz),
        .MinGapUs  (MinGapUs)
    ) u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .refresh_en_i  (refresh_en_i),
        .gap_clr_i     ((state_q == DRAIN) && drv.drv_idle),
        .gap_run_i     (state_q == GAP),
        .refresh_hit_o (refresh_hit),
        .gap_done_o    (gap_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumLeds; i++) colour_q[i] <= '0;
        end else if (wr_hit) begin
            colour_q[wr_idx_i[AW-1:0]] <= rgb_t'(wr_rgb_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            go_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            for (int i = 0; i < NumLeds; i++) shadow_q[i] <= '0;
        end else begin
            if (state_q != IDLE && trigger) pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (trigger || pend_q) begin
                        state_q <= LOAD;
                        pend_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    // Outputs come straight from the colour regs so word 0 is valid on SEND entry.
                    shadow_q <= colour_q;
                    idx_q    <= '0;
                    data_q   <= rgb_to_grb(colour_q[0]);
                    go_q     <= 1'b1;
                    valid_q  <= 1'b1;
                    last_q   <= (NumLeds == 1);
                    state_q  <= SEND;
                end
                SEND: begin
                    if (drv.data_ack) begin
                        if (idx_q == LastIdx) begin
                            state_q <= DRAIN;
                            go_q    <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                        end else begin
                            idx_q  <= idx_nx;
                            data_q <= rgb_to_grb(shadow_q[idx_nx]);
                            last_q <= (idx_nx == LastIdx);
                        end
                    end
                end
                DRAIN: begin
                    if (drv.drv_idle) state_q <= GAP;
                end
                GAP: begin
                    if (gap_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgbled_ctrl.sv
// tb/tb_rgbled_ctrl.sv - directed self-checking bench for rgbled_ctrl
module tb_rgbled_ctrl;

    localparam int NL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_idx;
    logic [23:0] wr_rgb;
    logic        update;
    logic        update1;
    logic        refresh_en;
    logic        busy;
    logic        busy1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    logic [23:0] cap_data [NL];
    logic        cap_last [NL];
    logic        cap_go [NL];
    logic        cap_stable [NL];
    logic        go_after;
    logic        valid_after;
    logic        timeout;

    rgbled_if drv0 ();
    rgbled_if drv1 ();

    rgbled_ctrl #(.NumLeds(NL), .ClkFreq(1000), .RefreshHz(10), .MinGapUs(5000)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_rgb_i(wr_rgb),
        .update_i(update), .refresh_en_i(refresh_en), .busy_o(busy), .drv(drv0.master)
    );

    rgbled_ctrl #(.NumLeds(1), .ClkFreq(1000), .RefreshHz(10), .MinGapUs(5000)) dut1 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_rgb_i(wr_rgb),
        .update_i(update1), .refresh_en_i(1'b0), .busy_o(busy1), .drv(drv1.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic write(input logic idx, input logic [23:0] rgb);
        wr_en = 1'b1; wr_idx = idx; wr_rgb = rgb;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int t);
        t = 0;
        while (drv0.data_valid !== 1'b1 && t < limit) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_not_busy(input int limit, output int t);
        t = 0;
        while (busy !== 1'b0 && t < limit) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Driver model: acks each word after dly cycles, keeps idle low until shortly after the last ack.
    task automatic serve_frame(input int dly);
        int t;
        timeout = 1'b0;
        for (int k = 0; k < NL; k++) begin
            wait_valid(200, t);
            if (t >= 200) begin
                timeout = 1'b1;
                return;
            end
            drv0.drv_idle = 1'b0;
            cap_data[k] = drv0.data;
            cap_last[k] = drv0.data_last;
            cap_go[k]   = drv0.go;
            repeat (dly) @(negedge clk);
            cap_stable[k] = (drv0.data === cap_data[k]) && (drv0.data_valid === 1'b1);
            drv0.data_ack = 1'b1;
            @(negedge clk);
            drv0.data_ack = 1'b0;
        end
        go_after    = drv0.go;
        valid_after = drv0.data_valid;
        repeat (2) @(negedge clk);
        drv0.drv_idle = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_idx = 1'b0; wr_rgb = '0;
        update = 1'b0; update1 = 1'b0; refresh_en = 1'b0;
        drv0.data_ack = 1'b0; drv0.drv_idle = 1'b1;
        drv1.data_ack = 1'b0; drv1.drv_idle = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (drv0.go !== 1'b0) begin errors++; $display("FAIL reset_go got=%b exp=0", drv0.go); end
        checks++; if (drv0.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", drv0.data_valid); end
        checks++; if (drv0.data_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", drv0.data_last); end
        checks++; if (drv0.data !== 24'h000000) begin errors++; $display("FAIL reset_data got=%h exp=000000", drv0.data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (drv1.data_valid !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 valid=%b busy=%b exp=0/0", drv1.data_valid, busy1); end
    endtask

    task automatic test_basic_frame();
        int t;
        write(1'b0, 24'hFF0000);
        write(1'b1, 24'h0000FF);
        pulse_update();
        serve_frame(3);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", timeout); end
        checks++; if (cap_data[0] !== 24'h00FF00) begin errors++; $display("FAIL basic_w0 got=%h exp=00ff00", cap_data[0]); end
        checks++; if (cap_last[0] !== 1'b0) begin errors++; $display("FAIL basic_l0 got=%b exp=0", cap_last[0]); end
        checks++; if (cap_go[0] !== 1'b1) begin errors++; $display("FAIL basic_go got=%b exp=1", cap_go[0]); end
        checks++; if (cap_stable[0] !== 1'b1) begin errors++; $display("FAIL basic_hold got=%b exp=1", cap_stable[0]); end
        checks++; if (cap_data[1] !== 24'h0000FF) begin errors++; $display("FAIL basic_w1 got=%h exp=0000ff", cap_data[1]); end
        checks++; if (cap_last[1] !== 1'b1) begin errors++; $display("FAIL basic_l1 got=%b exp=1", cap_last[1]); end
        checks++; if (go_after !== 1'b0 || valid_after !== 1'b0) begin errors++; $display("FAIL basic_go_fall go=%b valid=%b exp=0/0", go_after, valid_after); end
        wait_not_busy(50, t);
        checks++; if (t >= 50) begin errors++; $display("FAIL basic_end busy=%b exp=0", busy); end
    endtask

    task automatic test_write_in_send();
        int t;
        pulse_update();
        wait_valid(50, t);
        write(1'b0, 24'h112233);
        serve_frame(0);
        checks++; if (cap_data[0] !== 24'h00FF00) begin errors++; $display("FAIL shadow_old got=%h exp=00ff00", cap_data[0]); end
        wait_not_busy(50, t);
        pulse_update();
        serve_frame(1);
        checks++; if (cap_data[0] !== 24'h221133) begin errors++; $display("FAIL shadow_new got=%h exp=221133", cap_data[0]); end
        wait_not_busy(50, t);
        pulse_update();
        write(1'b1, 24'h0A0B0C);
        serve_frame(0);
        checks++; if (cap_data[1] !== 24'h0000FF) begin errors++; $display("FAIL load_race_old got=%h exp=0000ff", cap_data[1]); end
        wait_not_busy(50, t);
        pulse_update();
        serve_frame(0);
        checks++; if (cap_data[1] !== 24'h0B0A0C) begin errors++; $display("FAIL load_race_new got=%h exp=0b0a0c", cap_data[1]); end
        wait_not_busy(50, t);
    endtask

    task automatic test_pending();
        int t;
        int n;
        pulse_update();
        wait_valid(50, t);
        pulse_update();
        @(negedge clk);
        pulse_update();
        serve_frame(2);
        // DRAIN->GAP 1 cycle, 5 GAP cycles, IDLE 1, LOAD 1 before valid is seen.
        wait_valid(100, t);
        checks++; if (t !== 8) begin errors++; $display("FAIL pend_gap cycles got=%0d exp=8", t); end
        serve_frame(0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL pend_frame timeout got=%b exp=0", timeout); end
        wait_not_busy(50, t);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (drv0.go === 1'b1 || busy === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL pend_merge extra_cycles got=%0d exp=0", n); end
    endtask

    task automatic test_refresh();
        int t;
        int n;
        int c0;
        int s1;
        int s2;
        int s3;
        refresh_en = 1'b1;
        c0 = cyc;
        wait_valid(150, t);
        s1 = cyc;
        checks++; if (s1 - c0 !== 101) begin errors++; $display("FAIL refresh_first got=%0d exp=101", s1 - c0); end
        serve_frame(0);
        wait_valid(150, t);
        s2 = cyc;
        checks++; if (s2 - s1 !== 100) begin errors++; $display("FAIL refresh_period1 got=%0d exp=100", s2 - s1); end
        serve_frame(0);
        wait_valid(150, t);
        s3 = cyc;
        checks++; if (s3 - s2 !== 100) begin errors++; $display("FAIL refresh_period2 got=%0d exp=100", s3 - s2); end
        serve_frame(0);
        refresh_en = 1'b0;
        wait_not_busy(50, t);
        n = 0;
        repeat (250) begin
            @(negedge clk);
            if (drv0.data_valid === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL refresh_off valid_cycles got=%0d exp=0", n); end
    endtask

    task automatic test_ack_held();
        int t;
        drv0.data_ack = 1'b1;
        for (int f = 0; f < 2; f++) begin
            pulse_update();
            wait_valid(50, t);
            drv0.drv_idle = 1'b0;
            checks++; if (drv0.data !== 24'h221133 || drv0.data_last !== 1'b0) begin errors++; $display("FAIL held_w0 f=%0d data=%h last=%b exp=221133/0", f, drv0.data, drv0.data_last); end
            @(negedge clk);
            checks++; if (drv0.data_valid !== 1'b1 || drv0.data !== 24'h0B0A0C || drv0.data_last !== 1'b1) begin errors++; $display("FAIL held_w1 f=%0d valid=%b data=%h last=%b exp=1/0b0a0c/1", f, drv0.data_valid, drv0.data, drv0.data_last); end
            @(negedge clk);
            checks++; if (drv0.data_valid !== 1'b0 || drv0.go !== 1'b0) begin errors++; $display("FAIL held_end f=%0d valid=%b go=%b exp=0/0", f, drv0.data_valid, drv0.go); end
            drv0.drv_idle = 1'b1;
            wait_not_busy(50, t);
        end
        drv0.data_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t;
        pulse_update();
        wait_valid(50, t);
        checks++; if (t >= 50) begin errors++; $display("FAIL rstmid_start valid=%b exp=1", drv0.data_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (drv0.go !== 1'b0 || drv0.data_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_out go=%b valid=%b busy=%b exp=0/0/0", drv0.go, drv0.data_valid, busy); end
        rst = 1'b0;
        @(negedge clk);
        pulse_update();
        serve_frame(0);
        checks++; if (cap_data[0] !== 24'h000000 || cap_data[1] !== 24'h000000) begin errors++; $display("FAIL rstmid_colours got=%h,%h exp=000000,000000", cap_data[0], cap_data[1]); end
        checks++; if (cap_last[1] !== 1'b1) begin errors++; $display("FAIL rstmid_last got=%b exp=1", cap_last[1]); end
        wait_not_busy(50, t);
    endtask

    task automatic test_single_led();
        int t;
        write(1'b0, 24'hAABBCC);
        write(1'b1, 24'h010203);
        update1 = 1'b1;
        @(negedge clk);
        update1 = 1'b0;
        t = 0;
        while (drv1.data_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++; if (drv1.data !== 24'hBBAACC || drv1.data_last !== 1'b1) begin errors++; $display("FAIL single_word data=%h last=%b exp=bbaacc/1", drv1.data, drv1.data_last); end
        drv1.data_ack = 1'b1;
        @(negedge clk);
        drv1.data_ack = 1'b0;
        checks++; if (drv1.data_valid !== 1'b0 || drv1.go !== 1'b0) begin errors++; $display("FAIL single_end valid=%b go=%b exp=0/0", drv1.data_valid, drv1.go); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_write_in_send();
        test_pending();
        test_refresh();
        test_ack_held();
        test_reset_mid();
        test_single_led();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
